// File: rtl/lustre_neg_seq_if.sv
`timescale 1ns/1ps
// Request/response handshake bundle for the digit-serial unary arithmetic unit.
// The producer/consumer side uses master; the unit itself uses slave.
interface lustre_neg_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [N-1:0] arg;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res;
    logic         flag_Z;
    logic         flag_N;
    logic         flag_C;
    logic         flag_V;

    modport master (
        output in_valid, mode, arg, out_ready,
        input  in_ready, out_valid, res, flag_Z, flag_N, flag_C, flag_V
    );

    modport slave (
        input  in_valid, mode, arg, out_ready,
        output in_ready, out_valid, res, flag_Z, flag_N, flag_C, flag_V
    );
endinterface

// File: rtl/lustre_neg_seq.sv
`timescale 1ns/1ps
// Digit-serial PASS/NEG/ABS/ONES unit: res = (inv ? ~arg : arg) + cin, K bits per
// clock LSB first, with Z/N/C/V flags registered on the final beat.
module lustre_neg_seq #(
    parameter int N = 8,
    parameter int K = 4
) (
    input logic             clock,
    input logic             reset,
    lustre_neg_seq_if.slave bus
);
    localparam int BEATS = (K >= 1) ? N / K : 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = $clog2(N + 1);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;
    localparam logic [1:0] MODE_ONES = 2'b11;

    generate
        if (N < 1 || K < 1 || K > N || (N % K) != 0) begin : g_bad_cfg
            $error("lustre_neg_seq: illegal N/K combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_reg;
    logic [N-1:0]   a_reg;
    logic           carry_reg;
    logic [CW-1:0]  beat_reg;
    logic           z_acc_reg;
    logic [N-1:0]   res_reg;
    logic           out_valid_reg;
    logic           flag_z_reg;
    logic           flag_n_reg;
    logic           flag_c_reg;
    logic           flag_v_reg;

    logic           inv;
    logic           cin;
    logic [IW-1:0]  beat_off;
    logic [K-1:0]   slice;
    logic [K-1:0]   sum;
    logic           sum_carry;
    logic           last_beat;

    // ABS is resolved from the sign bit here, once, at acceptance.
    always_comb begin
        inv = 1'b0;
        cin = 1'b0;
        case (bus.mode)
            MODE_PASS: begin
                inv = 1'b0;
                cin = 1'b0;
            end
            MODE_NEG: begin
                inv = 1'b1;
                cin = 1'b1;
            end
            MODE_ABS: begin
                inv = bus.arg[N-1];
                cin = bus.arg[N-1];
            end
            MODE_ONES: begin
                inv = 1'b1;
                cin = 1'b0;
            end
            default: begin
                inv = 1'b0;
                cin = 1'b0;
            end
        endcase
    end

    always_comb begin
        beat_off  = IW'(beat_reg) * IW'(K);
        slice     = a_reg[beat_off +: K];
        {sum_carry, sum} = {1'b0, slice} + {{K{1'b0}}, carry_reg};
        last_beat = (beat_reg == CW'(BEATS - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            carry_reg     <= 1'b0;
            beat_reg      <= '0;
            z_acc_reg     <= 1'b0;
            res_reg       <= '0;
            out_valid_reg <= 1'b0;
            flag_z_reg    <= 1'b0;
            flag_n_reg    <= 1'b0;
            flag_c_reg    <= 1'b0;
            flag_v_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= inv ? ~bus.arg : bus.arg;
                        carry_reg <= cin;
                        beat_reg  <= '0;
                        z_acc_reg <= 1'b0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    res_reg[beat_off +: K] <= sum;
                    carry_reg <= sum_carry;
                    z_acc_reg <= z_acc_reg | (|sum);
                    if (last_beat) begin
                        // The last slice holds the MSB, so N and V come straight from it.
                        flag_c_reg    <= sum_carry;
                        flag_n_reg    <= sum[K-1];
                        flag_z_reg    <= ~(z_acc_reg | (|sum));
                        flag_v_reg    <= ~a_reg[N-1] & sum[K-1];
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.res       = res_reg;
    assign bus.flag_Z    = flag_z_reg;
    assign bus.flag_N    = flag_n_reg;
    assign bus.flag_C    = flag_c_reg;
    assign bus.flag_V    = flag_v_reg;
endmodule

// File: tb/tb_lustre_neg_seq.sv
`timescale 1ns/1ps
// Bench for lustre_neg_seq: N=8/K=4 vector table and handshake/reset sequences,
// plus randomized runs on N=1/K=1, N=16/K=16 and N=32/K=8 instances.
module tb_lustre_neg_seq;
    localparam logic [1:0] M_PASS = 2'b00;
    localparam logic [1:0] M_NEG  = 2'b01;
    localparam logic [1:0] M_ABS  = 2'b10;
    localparam logic [1:0] M_ONES = 2'b11;
    localparam int NVEC = 12;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] arg;
        exp_t       e;
    } vec_t;

    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic rst_cfg = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   cfg_done = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    lustre_neg_seq_if #(.N(8)) bus ();
    lustre_neg_seq #(.N(8), .K(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model8(input logic [1:0] m, input logic [7:0] a);
        logic       inv;
        logic       cin;
        logic [7:0] ap;
        logic [8:0] full;
        exp_t       e;
        inv    = (m == M_NEG) || (m == M_ONES) || (m == M_ABS && a[7]);
        cin    = (m == M_NEG) || (m == M_ABS && a[7]);
        ap     = inv ? ~a : a;
        full   = {1'b0, ap} + {8'd0, cin};
        e.res  = full[7:0];
        e.z    = (full[7:0] == 8'd0);
        e.n    = full[7];
        e.c    = full[8];
        e.v    = ~ap[7] & full[7];
        return e;
    endfunction

    // Drives a request, waits for in_ready, pushes the expectation on the accepting edge.
    task automatic accept(input string nm, input logic [1:0] m, input logic [7:0] a, input exp_t e);
        int guard = 0;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.arg      = a;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk({nm, "_accept"}, bus.in_ready, 1);
        @(posedge clock);
        sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        bus.mode     = ~m;
        bus.arg      = ~a;
    endtask

    task automatic wait_out(input string nm, input int beats);
        int lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, beats);
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({nm, "_out_valid"}, bus.out_valid, 1);
            chk({nm, "_res"}, bus.res, e.res);
            chk({nm, "_Z"}, bus.flag_Z, e.z);
            chk({nm, "_N"}, bus.flag_N, e.n);
            chk({nm, "_C"}, bus.flag_C, e.c);
            chk({nm, "_V"}, bus.flag_V, e.v);
        end
    endtask

    task automatic xfer(input string nm);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk({nm, "_valid_drop"}, bus.out_valid, 0);
        chk({nm, "_ready_back"}, bus.in_ready, 1);
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int CN = (gi == 0) ? 1 : (gi == 1) ? 16 : 32;
            localparam int CK = (gi == 0) ? 1 : (gi == 1) ? 16 : 8;
            localparam int CB = CN / CK;

            lustre_neg_seq_if #(.N(CN)) cbus ();
            lustre_neg_seq #(.N(CN), .K(CK)) cdut (.clock(clock), .reset(rst_cfg), .bus(cbus));

            logic [CN+3:0] csb[$];

            initial begin : run
                logic [CN-1:0] a;
                logic [CN-1:0] ap;
                logic [CN:0]   full;
                logic [1:0]    m;
                logic          inv;
                logic          cin;
                logic [CN+3:0] want;
                logic [CN+3:0] got;
                int            lat;
                int            guard;
                cbus.in_valid  = 1'b0;
                cbus.mode      = 2'b00;
                cbus.arg       = '0;
                cbus.out_ready = 1'b1;
                @(negedge rst_cfg);
                for (int t = 0; t < 24; t++) begin
                    if (t < 2) m = M_NEG;
                    else       m = 2'($urandom_range(0, 3));
                    if (t == 0) begin
                        a = '0;
                    end else if (t == 1) begin
                        a = '0;
                        a[CN-1] = 1'b1;
                    end else begin
                        a = CN'($urandom());
                    end
                    inv  = (m == M_NEG) || (m == M_ONES) || (m == M_ABS && a[CN-1]);
                    cin  = (m == M_NEG) || (m == M_ABS && a[CN-1]);
                    ap   = inv ? ~a : a;
                    full = {1'b0, ap} + (CN+1)'(cin);
                    want = {full[CN-1:0], (full[CN-1:0] == '0), full[CN-1], full[CN],
                            ~ap[CN-1] & full[CN-1]};
                    @(negedge clock);
                    cbus.in_valid = 1'b1;
                    cbus.mode     = m;
                    cbus.arg      = a;
                    guard = 0;
                    while (!cbus.in_ready && guard < 50) begin
                        @(negedge clock);
                        guard++;
                    end
                    chk($sformatf("cfg%0d_accept_%0d", gi, t), cbus.in_ready, 1);
                    @(posedge clock);
                    csb.push_back(want);
                    #1;
                    cbus.in_valid = 1'b0;
                    cbus.arg      = ~a;
                    lat = 0;
                    while (!cbus.out_valid && lat < 40) begin
                        @(posedge clock);
                        #1;
                        lat++;
                    end
                    chk($sformatf("cfg%0d_latency_%0d", gi, t), lat, CB);
                    if (csb.size() == 0) begin
                        chk($sformatf("cfg%0d_scoreboard_empty_%0d", gi, t), 1, 0);
                    end else begin
                        want = csb.pop_front();
                        got  = {cbus.res, cbus.flag_Z, cbus.flag_N, cbus.flag_C, cbus.flag_V};
                        chk($sformatf("cfg%0d_res_flags_%0d_mode%0d_arg%0h", gi, t, m, a), got, want);
                    end
                    @(posedge clock);
                    #1;
                end
                cfg_done++;
            end
        end
    endgenerate

    initial begin
        vec_t vecs[NVEC];
        exp_t e;
        int   seen;
        int   guard;

        // {mode, arg, res, Z N C V}
        vecs[0]  = {M_NEG,  8'h05, 8'hFB, 4'b0100};
        vecs[1]  = {M_NEG,  8'h00, 8'h00, 4'b1010};
        vecs[2]  = {M_NEG,  8'h80, 8'h80, 4'b0101};
        vecs[3]  = {M_ABS,  8'hFB, 8'h05, 4'b0000};
        vecs[4]  = {M_ABS,  8'h05, 8'h05, 4'b0000};
        vecs[5]  = {M_PASS, 8'h7F, 8'h7F, 4'b0000};
        vecs[6]  = {M_ONES, 8'h0F, 8'hF0, 4'b0100};
        vecs[7]  = {M_PASS, 8'h80, 8'h80, 4'b0100};
        vecs[8]  = {M_ONES, 8'hFF, 8'h00, 4'b1000};
        vecs[9]  = {M_ABS,  8'h80, 8'h80, 4'b0101};
        vecs[10] = {M_PASS, 8'h00, 8'h00, 4'b1000};
        vecs[11] = {M_NEG,  8'h01, 8'hFF, 4'b0100};

        bus.in_valid  = 1'b0;
        bus.mode      = M_PASS;
        bus.arg       = 8'h00;
        bus.out_ready = 1'b1;

        #1;
        reset   = 1'b1;
        rst_cfg = 1'b1;
        #2;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_res", bus.res, 0);
        chk("reset_flags", {bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V}, 0);
        @(negedge clock);
        reset   = 1'b0;
        rst_cfg = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            accept($sformatf("vec%0d", i), vecs[i].mode, vecs[i].arg, vecs[i].e);
            wait_out($sformatf("vec%0d", i), 2);
            check_out($sformatf("vec%0d_mode%0d_arg%0h", i, vecs[i].mode, vecs[i].arg));
            xfer($sformatf("vec%0d", i));
        end

        // Backpressure: result held while a competing request waits at the input.
        bus.out_ready = 1'b0;
        e = model8(M_PASS, 8'h5A);
        accept("bp", M_PASS, 8'h5A, e);
        bus.in_valid = 1'b1;
        bus.mode     = M_PASS;
        bus.arg      = 8'h33;
        wait_out("bp", 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp_hold%0d_valid", c), bus.out_valid, 1);
            chk($sformatf("bp_hold%0d_in_ready", c), bus.in_ready, 0);
            chk($sformatf("bp_hold%0d_res", c), bus.res, e.res);
            chk($sformatf("bp_hold%0d_flags", c), {bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V},
                {e.z, e.n, e.c, e.v});
        end
        check_out("bp_result");
        xfer("bp_release");
        accept("bp_next", M_PASS, 8'h33, model8(M_PASS, 8'h33));
        wait_out("bp_next", 2);
        check_out("bp_next_result");
        xfer("bp_next");

        // Asynchronous reset in the middle of BUSY discards the operation.
        accept("abort", M_NEG, 8'h05, model8(M_NEG, 8'h05));
        #2;
        reset = 1'b1;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_res", bus.res, 0);
        chk("abort_flags", {bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V}, 0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("abort_no_out_valid", seen, 0);
        accept("fresh", M_NEG, 8'h01, model8(M_NEG, 8'h01));
        wait_out("fresh", 2);
        check_out("fresh_neg01");
        xfer("fresh");

        guard = 0;
        while (cfg_done < 3 && guard < 5000) begin
            @(posedge clock);
            guard++;
        end
        chk("cfg_runs_complete", cfg_done, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lustre_neg_seq.md
# lustre_neg_seq

Digit-serial two's-complement unary arithmetic unit for the Lustre standard library. It computes negation, absolute value, pass-through or bitwise complement of an N-bit operand, K bits per clock, behind valid/ready handshakes. It also produces the Z/N/C/V flags that the combinational adder path reports. It is used where wide operands make a single-cycle N-bit carry chain too long, or where unary operators share a pipelined datapath.

## Interface
Parameters:
- N, default 8: operand/result width; N >= 1.
- K, default 4: bits processed per cycle; 1 <= K <= N, and N % K == 0. Any other combination is an elaboration error. BEATS = N/K.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- in_valid, input, 1: request present.
- in_ready, output, 1: unit can accept a request.
- mode, input, 2: operation select. 00 PASS, 01 NEG, 10 ABS, 11 ONES.
- arg, input, N: operand, two's complement.
- out_valid, output, 1: result and flags valid.
- out_ready, input, 1: consumer accepts the result.
- res, output, N: result.
- flag_Z, flag_N, flag_C, flag_V, output, 1 each: zero, negative, carry-out, signed overflow.

## Operation
- Every mode is evaluated as res = A' + 0 + cin, where A' = inv ? ~arg : arg.
  - PASS: inv=0, cin=0.
  - NEG: inv=1, cin=1.
  - ONES: inv=1, cin=0.
  - ABS: behaves as NEG if arg[N-1]=1, otherwise as PASS. This is resolved once, at acceptance.
- State machine states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid=1, the unit latches arg, inv, cin, clears the beat counter, and moves to BUSY.
  - BUSY: each cycle processes beat b (bits b*K .. b*K+K-1, LSB first). That slice of res is A'-slice + carry. The carry register is updated and the Z accumulator ORs the slice. After beat BEATS-1 the state moves to DONE.
  - DONE: out_valid=1. res and flags are held stable until out_ready=1, then the state moves to IDLE.
- in_ready = (state==IDLE). It is combinational from the state register only, with no path from out_ready.
- arg and mode are sampled only on an accepted transfer. Later changes are ignored.
- Flags are registered on the final beat:
  - flag_C = carry out of bit N-1.
  - flag_N = res[N-1].
  - flag_Z = (res == 0).
  - flag_V = ~A'[N-1] & res[N-1], because the rhs is zero and has sign 0.
- The carry chain is at most K bits deep per cycle.
- In BUSY and DONE, in_valid is ignored. No request is lost: the producer must hold it until in_ready.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, so in_ready=1 while reset is high.
  - out_valid=0, res=0, all flags 0.
  - carry, beat counter and Z accumulator are cleared.
- Latency: a request accepted at rising edge E produces out_valid=1 after edge E+BEATS.
- With out_ready held high, the result transfers at edge E+BEATS+1 and in_ready rises after it. The next acceptance can occur at E+BEATS+2.
- Throughput: one operation per BEATS+2 cycles.
- Back-to-back acceptance is not supported. There is no accept in DONE, even when out_ready=1 in the same cycle.
- K=N: BEATS=1, so there is a single BUSY cycle.
- Reset during BUSY or DONE aborts the operation. No out_valid pulse follows, and the pending result is discarded.
- res is updated slice by slice during BUSY but is only defined while out_valid=1.

## Test plan
- N=8, K=4, NEG arg=0x05, accepted at E0:
  - out_valid=0 after E1.
  - out_valid=1 after E2.
  - res=0xFB, Z=0, N=1, C=0, V=0.
- NEG arg=0x00: res=0x00, Z=1, N=0, C=1, V=0. NEG arg=0x80: res=0x80, N=1, C=0, V=1.
- ABS arg=0xFB: res=0x05, C=0, V=0. ABS arg=0x05: res=0x05, C=0. PASS arg=0x7F: res=0x7F. ONES arg=0x0F: res=0xF0, N=1, C=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid rises. res and flags stay stable, in_ready=0.
  - Present in_valid=1 with arg=0x33 throughout. It is not accepted.
  - On release, the transfer completes, in_ready returns to 1, and 0x33 is accepted next.
- Reset asserted asynchronously mid-BUSY:
  - All outputs go to their reset values immediately.
  - After release, no out_valid appears for the aborted request.
  - A fresh NEG 0x01 yields 0xFF.
- Configurations N=1,K=1; N=16,K=16; N=32,K=8: randomized compare against (inv ? ~arg : arg) + cin with reference flags. Latency equals BEATS in every case.
